// File: rtl/if_id_stage.sv
// IF->ID pipeline register with a two-entry skid buffer and opcode pre-decode.
// The head entry drives decode outputs; the skid entry absorbs the cycle of ready latency.
module if_id_stage #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_inst,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_inst,
    output logic [24:0]     id_inst_imm,
    output logic [2:0]      id_imm_sel,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic            id_illegal
);

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_B = 3'b001;
    localparam logic [2:0] IMM_U = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_S = 3'b100;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_if_ready;
    logic [XLEN-1:0]   r_head_pc;
    logic [31:0]       r_head_inst;
    logic [XLEN-1:0]   r_skid_pc;
    logic [31:0]       r_skid_inst;

    logic              w_acc;
    logic              w_pop;
    logic              w_valid;
    logic [31:0]       w_inst;
    logic [6:0]        w_opcode;

    assign w_valid = (r_state != S_EMPTY);
    assign w_acc   = if_valid & r_if_ready;
    assign w_pop   = w_valid & id_ready;

    // Occupancy FSM; if_ready is registered as "next state is not full".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_if_ready  <= 1'b1;
            r_head_pc   <= '0;
            r_head_inst <= '0;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
        end else if (flush) begin
            r_state    <= S_EMPTY;
            r_if_ready <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        r_head_pc   <= if_pc;
                        r_head_inst <= if_inst;
                        r_state     <= S_ONE;
                    end
                    r_if_ready <= 1'b1;
                end
                S_ONE: begin
                    if (w_acc && !w_pop) begin
                        r_skid_pc   <= if_pc;
                        r_skid_inst <= if_inst;
                        r_state     <= S_TWO;
                        r_if_ready  <= 1'b0;
                    end else if (w_acc && w_pop) begin
                        r_head_pc   <= if_pc;
                        r_head_inst <= if_inst;
                        r_if_ready  <= 1'b1;
                    end else if (w_pop) begin
                        r_state    <= S_EMPTY;
                        r_if_ready <= 1'b1;
                    end else begin
                        r_if_ready <= 1'b1;
                    end
                end
                S_TWO: begin
                    // Ready is low in this state, so only a pop can happen.
                    if (w_pop) begin
                        r_head_pc   <= r_skid_pc;
                        r_head_inst <= r_skid_inst;
                        r_state     <= S_ONE;
                        r_if_ready  <= 1'b1;
                    end else begin
                        r_if_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= S_EMPTY;
                    r_if_ready <= 1'b1;
                end
            endcase
        end
    end

    assign w_inst   = w_valid ? r_head_inst : NOP_INST;
    assign w_opcode = w_inst[6:0];

    // Opcode pre-decode into immediate format; an empty stage decodes as a bubble.
    always_comb begin
        id_imm_sel = IMM_I;
        id_illegal = 1'b0;
        case (w_opcode)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: id_imm_sel = IMM_I;
            7'b0100011:                                     id_imm_sel = IMM_S;
            7'b1100011:                                     id_imm_sel = IMM_B;
            7'b0110111, 7'b0010111:                         id_imm_sel = IMM_U;
            7'b1101111:                                     id_imm_sel = IMM_J;
            7'b0110011:                                     id_imm_sel = IMM_I;
            default:                                        id_illegal = 1'b1;
        endcase
    end

    assign if_ready    = r_if_ready;
    assign id_valid    = w_valid;
    assign id_pc       = w_valid ? r_head_pc : '0;
    assign id_inst     = w_inst;
    assign id_inst_imm = w_inst[31:7];
    assign id_rs1      = w_inst[19:15];
    assign id_rs2      = w_inst[24:20];
    assign id_rd       = w_inst[11:7];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed and random checks for the IF->ID skid stage against hand-derived values
// and a FIFO-order scoreboard.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [24:0] id_inst_imm;
    logic [2:0]  id_imm_sel;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_illegal;

    int tests;
    int fails;

    if_id_stage #(.XLEN(32), .NOP_INST(NOP)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .id_inst_imm (id_inst_imm),
        .id_imm_sel  (id_imm_sel),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_illegal  (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_pc = '0; if_inst = '0;
        #12;
        tests++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_handshake: id_valid=%b if_ready=%b, want 0/1", id_valid, if_ready);
        end
        tests++;
        if (id_pc !== 32'h0 || id_inst !== NOP || id_imm_sel !== 3'b000 || id_rd !== 5'd0 || id_illegal !== 1'b0) begin
            fails++;
            $display("FAIL reset_nop: pc=%h inst=%h sel=%b rd=%0d ill=%b, want 0/00000013/000/0/0",
                     id_pc, id_inst, id_imm_sel, id_rd, id_illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        if_valid = 1'b1; if_pc = 32'h0; if_inst = 32'h0050_0093; id_ready = 1'b0;
        cyc();
        if_valid = 1'b0;
        tests++;
        if (id_valid !== 1'b1 || id_imm_sel !== 3'b000 || id_inst_imm !== 25'h000A001 ||
            id_rd !== 5'd1 || id_rs1 !== 5'd0 || id_illegal !== 1'b0) begin
            fails++;
            $display("FAIL single_addi: v=%b sel=%b imm=%h rd=%0d rs1=%0d ill=%b, want 1/000/000a001/1/0/0",
                     id_valid, id_imm_sel, id_inst_imm, id_rd, id_rs1, id_illegal);
        end
        id_ready = 1'b1;
        cyc();
        tests++;
        if (id_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drain: id_valid=%b, want 0", id_valid);
        end
    endtask

    task automatic test_stream();
        logic [31:0] insts [4];
        logic [2:0]  sels  [4];
        insts[0] = 32'h0020_A423; sels[0] = 3'b100;
        insts[1] = 32'h0020_8463; sels[1] = 3'b001;
        insts[2] = 32'h0080_00EF; sels[2] = 3'b011;
        insts[3] = 32'h0001_20B7; sels[3] = 3'b010;
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_valid = 1'b1; if_pc = 32'h40 + 32'(i * 4); if_inst = insts[i];
            cyc();
            tests++;
            if (id_valid !== 1'b1 || id_imm_sel !== sels[i] || if_ready !== 1'b1 ||
                id_pc !== 32'h40 + 32'(i * 4)) begin
                fails++;
                $display("FAIL stream_%0d: v=%b sel=%b rdy=%b pc=%h, want 1/%b/1/%h",
                         i, id_valid, id_imm_sel, if_ready, id_pc, sels[i], 32'h40 + 32'(i * 4));
            end
        end
        if_valid = 1'b0;
        cyc();
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'h0010_0113;
        cyc();
        tests++;
        if (if_ready !== 1'b1 || id_pc !== 32'h100) begin
            fails++;
            $display("FAIL stall_first: rdy=%b pc=%h, want 1/00000100", if_ready, id_pc);
        end
        if_pc = 32'h104; if_inst = 32'h0020_0193;
        cyc();
        tests++;
        if (if_ready !== 1'b0 || id_pc !== 32'h100) begin
            fails++;
            $display("FAIL stall_full: rdy=%b pc=%h, want 0/00000100", if_ready, id_pc);
        end
        if_pc = 32'h108; if_inst = 32'h0030_0213;
        cyc();
        tests++;
        if (if_ready !== 1'b0 || id_pc !== 32'h100 || id_inst !== 32'h0010_0113) begin
            fails++;
            $display("FAIL stall_hold: rdy=%b pc=%h inst=%h, want 0/00000100/00100113", if_ready, id_pc, id_inst);
        end
        id_ready = 1'b1;
        cyc();
        tests++;
        if (id_pc !== 32'h104 || id_inst !== 32'h0020_0193 || if_ready !== 1'b1) begin
            fails++;
            $display("FAIL drain_second: pc=%h inst=%h rdy=%b, want 00000104/00200193/1", id_pc, id_inst, if_ready);
        end
        cyc();
        if_valid = 1'b0;
        tests++;
        if (id_pc !== 32'h108 || id_valid !== 1'b1 || id_rd !== 5'd4) begin
            fails++;
            $display("FAIL drain_third: pc=%h v=%b rd=%0d, want 00000108/1/4", id_pc, id_valid, id_rd);
        end
        cyc();
        tests++;
        if (id_valid !== 1'b0) begin
            fails++;
            $display("FAIL drain_empty: id_valid=%b, want 0", id_valid);
        end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h200; if_inst = 32'h0020_A423;
        cyc();
        if_pc = 32'h204;
        cyc();
        flush = 1'b1; if_pc = 32'h208; if_inst = 32'h0080_00EF;
        cyc();
        flush = 1'b0; if_valid = 1'b0;
        tests++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_handshake: v=%b rdy=%b, want 0/1", id_valid, if_ready);
        end
        tests++;
        if (id_inst !== NOP || id_pc !== 32'h0 || id_imm_sel !== 3'b000 || id_rd !== 5'd0 || id_illegal !== 1'b0) begin
            fails++;
            $display("FAIL flush_nop: inst=%h pc=%h sel=%b rd=%0d ill=%b, want 00000013/0/000/0/0",
                     id_inst, id_pc, id_imm_sel, id_rd, id_illegal);
        end
        id_ready = 1'b1;
        cyc();
        tests++;
        if (id_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_gone: id_valid=%b pc=%h, want 0", id_valid, id_pc);
        end
    endtask

    task automatic test_illegal_reset();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h300; if_inst = 32'hFFFF_FFFF;
        cyc();
        tests++;
        if (id_illegal !== 1'b1 || id_imm_sel !== 3'b000) begin
            fails++;
            $display("FAIL illegal: ill=%b sel=%b, want 1/000", id_illegal, id_imm_sel);
        end
        if_pc = 32'h304; if_inst = 32'h0000_0033;
        cyc();
        if_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || id_illegal !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: v=%b rdy=%b ill=%b, want 0/1/0", id_valid, if_ready, id_illegal);
        end
        @(negedge clk);
        rst_n = 1'b1;
        if_valid = 1'b1; if_pc = 32'h400; if_inst = 32'h0000_0033;
        cyc();
        if_valid = 1'b0;
        tests++;
        if (id_valid !== 1'b1 || id_pc !== 32'h400 || id_illegal !== 1'b0 || id_imm_sel !== 3'b000) begin
            fails++;
            $display("FAIL post_reset: v=%b pc=%h ill=%b sel=%b, want 1/00000400/0/000",
                     id_valid, id_pc, id_illegal, id_imm_sel);
        end
        id_ready = 1'b1;
        cyc();
    endtask

    task automatic test_random();
        logic [31:0] q_pc [$];
        logic [31:0] q_inst [$];
        int          rfails;
        logic        acc;
        logic        pop;
        rfails = 0;
        q_pc.delete(); q_inst.delete();
        for (int c = 0; c < 10000; c++) begin
            if_valid = ($urandom_range(0, 3) != 0);
            id_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 31) == 0);
            if_pc    = $urandom;
            if_inst  = $urandom;
            @(negedge clk);
            tests++;
            if ($isunknown({id_valid, if_ready, id_pc, id_inst, id_imm_sel, id_illegal}) ||
                id_valid !== (q_pc.size() > 0) || if_ready !== (q_pc.size() < 2) ||
                (q_pc.size() > 0 && (id_pc !== q_pc[0] || id_inst !== q_inst[0]))) begin
                fails++;
                if (rfails < 10)
                    $display("FAIL random_c%0d: v=%b rdy=%b pc=%h inst=%h, want v=%b rdy=%b pc=%h inst=%h",
                             c, id_valid, if_ready, id_pc, id_inst, q_pc.size() > 0, q_pc.size() < 2,
                             (q_pc.size() > 0) ? q_pc[0] : 32'h0, (q_inst.size() > 0) ? q_inst[0] : NOP);
                rfails++;
            end
            acc = if_valid && (q_pc.size() < 2);
            pop = id_ready && (q_pc.size() > 0);
            if (flush) begin
                q_pc.delete(); q_inst.delete();
            end else begin
                if (pop) begin
                    void'(q_pc.pop_front());
                    void'(q_inst.pop_front());
                end
                if (acc) begin
                    q_pc.push_back(if_pc);
                    q_inst.push_back(if_inst);
                end
            end
            @(posedge clk);
            #1;
        end
        flush = 1'b0; if_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_flush();
        test_illegal_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
